// File: rtl/weight_pkg.sv
// Shared types and defaults for the weight loader: FSM encoding, kernel sizing
// and a one-hot helper for the write-enable bank.
package weight_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wld_state_e;

    localparam int F_WIDTH_DEF = 8;
    localparam int N_REGS_DEF  = 9;   // 3x3 kernel
    localparam int MAX_REGS    = 32;  // widest enable vector the helper can build

    function automatic logic [MAX_REGS-1:0] onehot(input logic [7:0] idx);
        return MAX_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Weight stream (valid/ready) plus the shared weight bus and write enables
// toward the PE weight registers.
interface weight_loader_if #(
    parameter int F_WIDTH = 8,
    parameter int N_REGS  = 9
);
    logic signed [F_WIDTH-1:0] s_weight;
    logic                      s_valid;
    logic                      s_ready;
    logic signed [F_WIDTH-1:0] f_weight;
    logic [N_REGS-1:0]         wreg_wr_en;

    // loader side
    modport slave (
        input  s_weight, s_valid,
        output s_ready, f_weight, wreg_wr_en
    );

    // buffer/controller + register-bank side
    modport master (
        output s_weight, s_valid,
        input  s_ready, f_weight, wreg_wr_en
    );
endinterface

// File: rtl/weight_loader.sv
// Loads one kernel of signed weights per start command into a bank of weight
// registers via a shared bus and one-hot write enables.
module weight_loader
    import weight_pkg::*;
#(
    parameter  int F_WIDTH = F_WIDTH_DEF,
    parameter  int N_REGS  = N_REGS_DEF,
    localparam int CNT_W   = $clog2(N_REGS + 1)
) (
    input  logic             clk_i,
    input  logic             wld_rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_weights_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    weight_loader_if.slave   bus
);

    wld_state_e       state, state_n;
    logic [CNT_W-1:0] idx, num_q, num_sat;
    logic             accept, last_beat;

    assign num_sat   = (num_weights_i > CNT_W'(N_REGS)) ? CNT_W'(N_REGS) : num_weights_i;
    assign accept    = bus.s_valid & bus.s_ready;
    assign last_beat = (idx == num_q - CNT_W'(1));

    always_ff @(posedge clk_i or posedge wld_rst_i) begin
        if (wld_rst_i) state <= IDLE;
        else           state <= state_n;
    end

    // abort wins over the last-beat transition
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start_i) state_n = (num_sat == '0) ? DONE : LOAD;
            LOAD: begin
                if (abort_i)                  state_n = IDLE;
                else if (accept && last_beat) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready = (state == LOAD);
        busy_o      = (state == LOAD);
        done_o      = (state == DONE);
    end

    // f_weight holds between beats; enables are single-cycle pulses
    always_ff @(posedge clk_i or posedge wld_rst_i) begin
        if (wld_rst_i) begin
            idx            <= '0;
            num_q          <= '0;
            bus.f_weight   <= '0;
            bus.wreg_wr_en <= '0;
        end else begin
            bus.wreg_wr_en <= '0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        num_q <= num_sat;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        idx <= '0;
                    end else if (accept) begin
                        bus.f_weight   <= bus.s_weight;
                        bus.wreg_wr_en <= N_REGS'(onehot(8'(idx)));
                        idx            <= idx + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: expected writes are queued as beats are
// driven and popped by a monitor whenever a write enable fires.
module tb_weight_loader;
    import weight_pkg::*;

    localparam int F_WIDTH = 8;
    localparam int N_REGS  = 9;
    localparam int CNT_W   = $clog2(N_REGS + 1);

    typedef struct {
        logic [N_REGS-1:0]         en;
        logic signed [F_WIDTH-1:0] w;
        logic                      done;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num = '0;
    logic             abort = 1'b0;
    logic             busy, done;

    weight_loader_if #(.F_WIDTH(F_WIDTH), .N_REGS(N_REGS)) bus ();

    weight_loader #(.F_WIDTH(F_WIDTH), .N_REGS(N_REGS)) dut (
        .clk_i         (clk),
        .wld_rst_i     (rst),
        .start_i       (start),
        .num_weights_i (num),
        .abort_i       (abort),
        .busy_o        (busy),
        .done_o        (done),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   exp_idx = 0;
    int   exp_num = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // monitor: every write enable must match the head of the scoreboard
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (bus.wreg_wr_en !== '0) begin
            exp_t e;
            wr_cnt++;
            check("wr_onehot", 32'($onehot(bus.wreg_wr_en)), 32'(1));
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(bus.wreg_wr_en), 32'(0));
            end else begin
                e = sb.pop_front();
                check("wr_en", 32'(bus.wreg_wr_en), 32'(e.en));
                check("f_weight", 32'(bus.f_weight), 32'(e.w));
                check("done_with_write", 32'(done), 32'(e.done));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num   = CNT_W'(n);
        exp_num = (n > N_REGS) ? N_REGS : n;
        exp_idx = 0;
        step();
        start = 1'b0;
    endtask

    // v=1 beats are expected to be accepted and are pushed to the scoreboard
    task automatic beat(input logic v, input logic signed [F_WIDTH-1:0] w);
        exp_t e;
        bus.s_valid  = v;
        bus.s_weight = w;
        if (v) begin
            check("s_ready_on_beat", 32'(bus.s_ready), 32'(1));
            e.en   = N_REGS'(1) << exp_idx;
            e.w    = w;
            e.done = (exp_idx == exp_num - 1);
            sb.push_back(e);
            exp_idx++;
        end
        step();
        bus.s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0;
        bus.s_valid  = 1'b0;
        bus.s_weight = '0;

        // reset state
        step(); step();
        check("rst_s_ready", 32'(bus.s_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_wr_en", 32'(bus.wreg_wr_en), 32'(0));
        check("rst_f_weight", 32'(bus.f_weight), 32'(0));
        rst = 1'b0;
        step();
        check("idle_s_ready", 32'(bus.s_ready), 32'(0));

        // full load, back-to-back beats -4..4
        do_start(9);
        check("full_busy", 32'(busy), 32'(1));
        for (int i = -4; i <= 4; i++) begin
            bus.s_valid = 1'b1;
            beat(1'b1, F_WIDTH'(i));
        end
        check("full_done_cycle", 32'(done), 32'(1));
        check("full_last_en", 32'(bus.wreg_wr_en), 32'h100);
        check("full_busy_done", 32'(busy), 32'(0));
        step();
        check("full_idle_ready", 32'(bus.s_ready), 32'(0));
        check("full_done_clear", 32'(done), 32'(0));
        check("full_wr_cnt", 32'(wr_cnt), 32'(9));
        check("full_done_cnt", 32'(done_cnt), 32'(1));

        // gapped valid 1,0,0,1,1 with a zero weight
        do_start(3);
        beat(1'b1, 8'sd10);
        beat(1'b0, 8'sd99);
        check("gap_en0", 32'(bus.wreg_wr_en), 32'(0));
        check("gap_hold0", 32'(bus.f_weight), 32'(8'sd10));
        beat(1'b0, -8'sd99);
        check("gap_hold1", 32'(bus.f_weight), 32'(8'sd10));
        beat(1'b1, -8'sd7);
        beat(1'b1, 8'sd0);
        check("gap_done", 32'(done), 32'(1));
        check("gap_zero_weight", 32'(bus.f_weight), 32'(0));
        step();
        check("gap_wr_cnt", 32'(wr_cnt), 32'(12));

        // saturation: num=12 gives 9 writes; an extra valid in DONE is refused
        do_start(12);
        for (int i = 0; i < 9; i++) beat(1'b1, F_WIDTH'(20 + i));
        check("sat_done", 32'(done), 32'(1));
        check("sat_ready_in_done", 32'(bus.s_ready), 32'(0));
        bus.s_valid = 1'b1;
        bus.s_weight = 8'sd55;
        step();
        bus.s_valid = 1'b0;
        step();
        check("sat_wr_cnt", 32'(wr_cnt), 32'(21));
        check("sat_done_cnt", 32'(done_cnt), 32'(3));

        // num=0: straight to DONE, no enables, never ready
        w0 = wr_cnt;
        bus.s_valid = 1'b1;
        check("zero_ready_pre", 32'(bus.s_ready), 32'(0));
        do_start(0);
        check("zero_done", 32'(done), 32'(1));
        check("zero_ready", 32'(bus.s_ready), 32'(0));
        check("zero_busy", 32'(busy), 32'(0));
        step();
        check("zero_done_clear", 32'(done), 32'(0));
        check("zero_ready_post", 32'(bus.s_ready), 32'(0));
        bus.s_valid = 1'b0;
        step();
        check("zero_no_writes", 32'(wr_cnt), 32'(w0));

        // abort with the 3rd beat: beat dropped, no done, back to IDLE
        d0 = done_cnt;
        do_start(5);
        beat(1'b1, 8'sd1);
        beat(1'b1, 8'sd2);
        abort = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_weight = 8'sd3;
        step();
        abort = 1'b0;
        bus.s_valid = 1'b0;
        check("abort_en_dropped", 32'(bus.wreg_wr_en), 32'(0));
        check("abort_idle_ready", 32'(bus.s_ready), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        step(); step();
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_wr_cnt", 32'(wr_cnt), 32'(w0 + 2));

        // start pulses during LOAD and in DONE are ignored
        do_start(4);
        beat(1'b1, -8'sd128);
        start = 1'b1;
        num   = CNT_W'(2);
        beat(1'b1, 8'sd127);
        start = 1'b0;
        beat(1'b1, -8'sd1);
        beat(1'b1, 8'sd64);
        check("ign_done", 32'(done), 32'(1));
        start = 1'b1;
        num   = CNT_W'(1);
        step();
        start = 1'b0;
        check("ign_idle_after_done", 32'(busy), 32'(0));
        check("ign_ready_after_done", 32'(bus.s_ready), 32'(0));
        step();
        check("ign_wr_cnt", 32'(wr_cnt), 32'(w0 + 6));

        // reset asserted mid-load clears outputs asynchronously
        do_start(9);
        beat(1'b1, 8'sd11);
        beat(1'b1, 8'sd12);
        bus.s_valid = 1'b1;
        bus.s_weight = 8'sd13;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", 32'(bus.wreg_wr_en), 32'(0));
        check("mid_rst_f_weight", 32'(bus.f_weight), 32'(0));
        check("mid_rst_ready", 32'(bus.s_ready), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        bus.s_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(bus.s_ready), 32'(0));
        check("post_rst_busy", 32'(busy), 32'(0));
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
